// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// vga_sync_gen
//   640x480@60 VGA timing generator running from a 100 MHz clock.
//   A free-running 2-bit divider produces a one-clk pix_en strobe every
//   4 clks. The pixel/line counters, sync outputs and blank advance only on
//   that strobe. HS, VS and blank are registered from the next counter values,
//   so they are always aligned with hcounter/vcounter.
//
//   Geometry parameters default to the standard 640x480 timing
//   (800 x 525 total, HS on columns 656..751, VS on lines 490..491).
//
//   Optional feature: define FRAME_COUNT_EN to build the 8-bit frame counter.
//   Without it, frame_count is tied to zero and no counter register exists.
//
// Ports
//   clk          in   system clock, rising-edge active
//   rst          in   asynchronous reset, active low
//   pix_en       out  one-clk pixel strobe (every 4th clk)
//   hcounter     out  current pixel column
//   vcounter     out  current line
//   HS           out  horizontal sync, active low
//   VS           out  vertical sync, active low
//   blank        out  high outside the visible area
//   frame_start  out  one-clk pulse after the counters wrap to (0,0)
//   frame_count  out  completed-frame counter (zero unless FRAME_COUNT_EN)

module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic [10:0] hcounter,
    output logic [10:0] vcounter,
    output logic        HS,
    output logic        VS,
    output logic        blank,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [1:0]  div;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        at_h_end;
    logic        at_v_end;
    logic        frame_wrap;

    always_comb begin
        at_h_end   = (hcounter == H_LAST);
        at_v_end   = (vcounter == V_LAST);
        frame_wrap = pix_en && at_h_end && at_v_end;
        h_next     = hcounter;
        v_next     = vcounter;
        if (pix_en) begin
            if (at_h_end) begin
                h_next = '0;
                v_next = at_v_end ? '0 : vcounter + 11'd1;
            end else begin
                h_next = hcounter + 11'd1;
            end
        end
    end

    // pix_en is registered from div==2 so it is high exactly while div==3.
    // Sync/blank decode the next counter values, keeping them aligned with
    // the counters they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div         <= '0;
            pix_en      <= 1'b0;
            hcounter    <= '0;
            vcounter    <= '0;
            HS          <= 1'b1;
            VS          <= 1'b1;
            blank       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div + 2'd1;
            pix_en      <= (div == 2'd2);
            hcounter    <= h_next;
            vcounter    <= v_next;
            HS          <= !((h_next >= HS_BEG) && (h_next < HS_END));
            VS          <= !((v_next >= VS_BEG) && (v_next < VS_END));
            blank       <= (h_next >= H_VIS) || (v_next >= V_VIS);
            frame_start <= frame_wrap;
        end
    end

`ifdef FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    // Counts on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`else
    assign frame_count = '0;
`endif

endmodule
